// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
//
// Merges the in-order W-stage result (primary, never stalled) and
// out-of-order long-latency results (secondary, valid/ready) onto the single
// general register file write port. Secondary results wait in a small FIFO
// until the primary leaves a free slot. Per-register pending status lets
// decode stall reads of registers still waiting in the FIFO.
//
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   PWe, PRd, PData      primary write request (PRd==0 means no request)
//   SValid, SRd, SData   secondary result, accepted when SValid && SReady
//   SReady               FIFO can accept a secondary result this cycle
//   QRs1/2, QBusy1/2     query: register has a live FIFO entry pending
//   RegWrite, RD, WData  registered GRF write port (1-cycle latency)
//   Count                FIFO occupancy, live plus killed entries
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          PWe,
    input  logic [4:0]    PRd,
    input  logic [31:0]   PData,
    input  logic          SValid,
    input  logic [4:0]    SRd,
    input  logic [31:0]   SData,
    output logic          SReady,
    input  logic [4:0]    QRs1,
    input  logic [4:0]    QRs2,
    output logic          QBusy1,
    output logic          QBusy2,
    output logic          RegWrite,
    output logic [4:0]    RD,
    output logic [31:0]   WData,
    output logic [AW:0]   Count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]       fifo_rd   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_live;
    logic [DEPTH-1:0] live_nxt;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW:0]      count;

    logic             vld_p1;
    logic [4:0]       rd_p1;
    logic [31:0]      wdata_p1;

    logic             prim_sel;
    logic             head_valid;
    logic             head_live;
    logic             sec_sel;
    logic             pop;
    logic             push;
    logic             busy1;
    logic             busy2;

    assign prim_sel   = PWe && (PRd != 5'd0);
    assign head_valid = (count != '0);
    assign head_live  = head_valid && fifo_live[head];
    assign sec_sel    = !prim_sel && head_live;
    // A killed head always drains; a live head only drains when it wins the port.
    assign pop        = head_valid && (!prim_sel || !head_live);
    // No push-through while full, even if the head pops this cycle.
    assign SReady     = !Reset && (count != FULL);
    assign push       = SValid && SReady && (SRd != 5'd0);

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live[i] && (fifo_rd[i] == QRs1)) busy1 = 1'b1;
            if (fifo_live[i] && (fifo_rd[i] == QRs2)) busy2 = 1'b1;
        end
    end

    assign QBusy1 = busy1 && (QRs1 != 5'd0);
    assign QBusy2 = busy2 && (QRs2 != 5'd0);

    // Live-bit update: WAW kill of older entries first, then pop, then the
    // push, so an entry enqueued alongside a same-register primary stays live.
    always_comb begin
        live_nxt = fifo_live;
        for (int i = 0; i < DEPTH; i++) begin
            if (prim_sel && (fifo_rd[i] == PRd)) live_nxt[i] = 1'b0;
        end
        if (pop)  live_nxt[head] = 1'b0;
        if (push) live_nxt[tail] = 1'b1;
    end

    // FIFO payload storage (data only, not reset)
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_rd[tail]   <= SRd;
            fifo_data[tail] <= SData;
        end
    end

    // ---- stage p0 -> p1 : arbitration and GRF write register ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            fifo_live <= '0;
            vld_p1    <= 1'b0;
            rd_p1     <= 5'd0;
            wdata_p1  <= 32'd0;
        end else begin
            fifo_live <= live_nxt;
            if (pop)  head <= head + AW'(1);
            if (push) tail <= tail + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (prim_sel) begin
                vld_p1   <= 1'b1;
                rd_p1    <= PRd;
                wdata_p1 <= PData;
            end else if (sec_sel) begin
                vld_p1   <= 1'b1;
                rd_p1    <= fifo_rd[head];
                wdata_p1 <= fifo_data[head];
            end else begin
                vld_p1   <= 1'b0;
            end
        end
    end

    assign RegWrite = vld_p1;
    assign RD       = rd_p1;
    assign WData    = wdata_p1;
    assign Count    = count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_write_arbiter
//
// Randomized bench for wb_write_arbiter. A queue-based model holds the
// pending secondary results in enqueue order with a live flag each; every
// cycle the DUT outputs are compared with the model and the model is then
// advanced by the same inputs.
// ---------------------------------------------------------------------------
module tb_wb_write_arbiter;

    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int CYCLES = 3000;

    logic          Clk;
    logic          Reset;
    logic          PWe;
    logic [4:0]    PRd;
    logic [31:0]   PData;
    logic          SValid;
    logic [4:0]    SRd;
    logic [31:0]   SData;
    logic          SReady;
    logic [4:0]    QRs1;
    logic [4:0]    QRs2;
    logic          QBusy1;
    logic          QBusy2;
    logic          RegWrite;
    logic [4:0]    RD;
    logic [31:0]   WData;
    logic [AW:0]   Count;

    wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PWe      (PWe),
        .PRd      (PRd),
        .PData    (PData),
        .SValid   (SValid),
        .SRd      (SRd),
        .SData    (SData),
        .SReady   (SReady),
        .QRs1     (QRs1),
        .QRs2     (QRs2),
        .QBusy1   (QBusy1),
        .QBusy2   (QBusy2),
        .RegWrite (RegWrite),
        .RD       (RD),
        .WData    (WData),
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].live && q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit   psel;
        bit   acc;
        ent_t e;
        if (Reset) begin
            q.delete();
            exp_we = 1'b0;
            exp_rd = 5'd0;
            exp_wd = 32'd0;
            return;
        end
        psel = PWe && (PRd != 5'd0);
        acc  = SValid && (q.size() < DEPTH) && (SRd != 5'd0);
        if (psel) begin
            exp_we = 1'b1;
            exp_rd = PRd;
            exp_wd = PData;
            // a head that was already dead drains even while primary writes
            if (q.size() > 0 && !q[0].live) void'(q.pop_front());
            // older pending writes to the same register are now stale
            foreach (q[i]) if (q[i].rd == PRd) q[i].live = 1'b0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            exp_we = e.live;
            if (e.live) begin
                exp_rd = e.rd;
                exp_wd = e.data;
            end
        end else begin
            exp_we = 1'b0;
        end
        if (acc) begin
            e.rd   = SRd;
            e.data = SData;
            e.live = 1'b1;
            q.push_back(e);
        end
    endtask

    function automatic logic [4:0] rand_reg();
        // narrow range so collisions and index 0 come up often
        return 5'($urandom_range(0, 11));
    endfunction

    initial begin
        int phase;
        int pwe_pct;
        n_vec  = 0;
        n_err  = 0;
        Reset  = 1'b1;
        PWe    = 1'b0;
        PRd    = 5'd0;
        PData  = 32'd0;
        SValid = 1'b0;
        SRd    = 5'd0;
        SData  = 32'd0;
        QRs1   = 5'd0;
        QRs2   = 5'd0;
        q.delete();
        exp_we = 1'b0;
        exp_rd = 5'd0;
        exp_wd = 32'd0;
        repeat (2) @(posedge Clk);

        for (int c = 0; c < CYCLES; c++) begin
            @(negedge Clk);
            phase = (c / 64) % 4;
            case (phase)
                0:       pwe_pct = 50;
                1:       pwe_pct = 95;
                2:       pwe_pct = 0;
                default: pwe_pct = 30;
            endcase
            Reset  = (c < 1) || ($urandom_range(0, 149) == 0);
            PWe    = ($urandom_range(0, 99) < pwe_pct);
            PRd    = rand_reg();
            PData  = $urandom;
            SValid = ($urandom_range(0, 99) < 60);
            SRd    = rand_reg();
            SData  = $urandom;
            QRs1   = rand_reg();
            QRs2   = (($urandom_range(0, 1) == 0) && (q.size() > 0)) ? q[q.size()-1].rd : rand_reg();
            #1;
            check("RegWrite", 32'(RegWrite), 32'(exp_we));
            check("RD",       32'(RD),       32'(exp_rd));
            check("WData",    WData,         exp_wd);
            check("Count",    32'(Count),    32'(q.size()));
            check("SReady",   32'(SReady),   32'(!Reset && (q.size() < DEPTH)));
            check("QBusy1",   32'(QBusy1),   32'(pending(QRs1)));
            check("QBusy2",   32'(QBusy2),   32'(pending(QRs2)));
            model_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
